// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : mips_ctrl_pkg                                              |
// | Purpose : Shared types and encodings for the multi-cycle MIPS        |
// |           control unit: FSM state enum, opcode/funct constants,      |
// |           ALU control codes and datapath mux encodings.              |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package mips_ctrl_pkg;

    // State codes are visible on the debug port, so the values are fixed.
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    // Coarse ALU request from the FSM; the ALU decoder refines FUNCT.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage : mips_ctrl_pkg
`default_nettype wire

// File: rtl/mips_multicycle_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : mips_multicycle_ctrl_if                                  |
// | Purpose   : Bundle between the control FSM and the shared datapath.  |
// |   Datapath -> ctrl : opcode, funct, zero, mem_ready                  |
// |   Ctrl -> datapath : pc_en, iord, mem_read, mem_write, ir_write,     |
// |                      reg_dst, mem_to_reg, reg_write, alu_src_a,      |
// |                      alu_src_b, pc_source, alu_ctl                   |
// |   master = control unit side, slave = datapath side                  |
// | Rev       : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_ctl;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_en, iord, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
               alu_ctl
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
               alu_ctl
    );
endinterface : mips_multicycle_ctrl_if
`default_nettype wire

// File: rtl/mips_alu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mips_alu_ctrl                                              |
// | Purpose : Combinational ALU decoder. Maps the FSM's ALUOp plus the   |
// |           R-type funct field to the 4-bit ALU control code, and      |
// |           flags whether funct is a supported R-type operation.       |
// | Ports   : alu_op (in 2), funct (in 6), alu_ctl (out 4),              |
// |           funct_ok (out 1)                                           |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module mips_alu_ctrl
    import mips_ctrl_pkg::*;
(
    input  aluop_t     alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctl,
    output logic       funct_ok
);

    logic [3:0] funct_ctl;

    // funct_ok is independent of alu_op so DECODE can use it for trapping.
    always_comb begin
        funct_ok  = 1'b1;
        funct_ctl = ALU_ADD;
        case (funct)
            FN_ADD:  funct_ctl = ALU_ADD;
            FN_SUB:  funct_ctl = ALU_SUB;
            FN_AND:  funct_ctl = ALU_AND;
            FN_OR:   funct_ctl = ALU_OR;
            FN_SLT:  funct_ctl = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        alu_ctl = ALU_ADD;
        case (alu_op)
            ALUOP_ADD:   alu_ctl = ALU_ADD;
            ALUOP_SUB:   alu_ctl = ALU_SUB;
            ALUOP_FUNCT: alu_ctl = funct_ctl;
            default:     alu_ctl = ALU_ADD;
        endcase
    end

endmodule : mips_alu_ctrl
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mips_multicycle_ctrl                                       |
// | Purpose : Moore FSM sequencing MIPS instructions (R-type, lw, sw,    |
// |           beq, addi, j) through fetch/decode/execute/memory/         |
// |           writeback, with memory wait states, a sticky illegal-      |
// |           instruction trap and a retired-instruction counter.        |
// | Ports   : clk, rst_n (async, active low), en (start next instr),     |
// |           bus (datapath interface, master side),                     |
// |           state (debug, 4), instr_done (last-cycle pulse),           |
// |           illegal (trap flag), retired (ICNT_W count, wraps)         |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int ENABLE_ADDI = 1,
    parameter int ENABLE_J    = 1,
    parameter int ICNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    mips_multicycle_ctrl_if.master bus,
    output logic [3:0]            state,
    output logic                  instr_done,
    output logic                  illegal,
    output logic [ICNT_W-1:0]     retired
);

    state_t     state_q;
    state_t     state_d;
    aluop_t     alu_op;
    logic [3:0] alu_ctl_w;
    logic       funct_ok;

    mips_alu_ctrl u_alu_ctrl (
        .alu_op   (alu_op),
        .funct    (bus.funct),
        .alu_ctl  (alu_ctl_w),
        .funct_ok (funct_ok)
    );

    assign bus.alu_ctl = alu_ctl_w;
    assign state       = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            retired <= '0;
        end else begin
            state_q <= state_d;
            if (instr_done) begin
                retired <= retired + ICNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        alu_op         = ALUOP_ADD;
        bus.pc_en      = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SRCB_B;
        bus.pc_source  = PCSRC_ALU;
        instr_done     = 1'b0;
        illegal        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en) state_d = S_FETCH;
            end
            S_FETCH: begin
                // PC+4 is computed every fetch cycle but only committed,
                // together with the IR, once memory returns the word.
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                bus.ir_write  = bus.mem_ready;
                bus.pc_en     = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut.
                bus.alu_src_b = SRCB_IMMSH2;
                case (bus.opcode)
                    OP_RTYPE: state_d = funct_ok ? S_EXEC : S_TRAP;
                    OP_LW,
                    OP_SW:    state_d = S_MEMADR;
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_ADDI:  state_d = (ENABLE_ADDI != 0) ? S_ADDIEX : S_TRAP;
                    OP_J:     state_d = (ENABLE_J != 0) ? S_JUMP : S_TRAP;
                    default:  state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                state_d       = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                instr_done     = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
                instr_done    = bus.mem_ready;
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                alu_op        = ALUOP_FUNCT;
                state_d       = S_ALUWB;
            end
            S_ALUWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                instr_done    = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                alu_op        = ALUOP_SUB;
                bus.pc_source = PCSRC_ALUOUT;
                bus.pc_en     = bus.zero;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                bus.pc_en     = 1'b1;
                bus.pc_source = PCSRC_JUMP;
                instr_done    = 1'b1;
            end
            S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                state_d       = S_ADDIWB;
            end
            S_ADDIWB: begin
                bus.reg_write = 1'b1;
                instr_done    = 1'b1;
            end
            S_TRAP: begin
                // Dead-end state; only reset leaves it, which makes the flag sticky.
                illegal = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Every final state shares the same hand-off: straight into the
        // next fetch when allowed, otherwise park in IDLE.
        if (instr_done) begin
            state_d = en ? S_FETCH : S_IDLE;
        end
    end

endmodule : mips_multicycle_ctrl
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_mips_multicycle_ctrl                                    |
// | Purpose : Self-checking bench. A per-instruction step model predicts |
// |           state and control outputs every cycle for a default DUT    |
// |           and an ICNT_W=2 DUT; a third DUT with addi/j disabled      |
// |           checks the parameterised traps.                            |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_mips_multicycle_ctrl;

    localparam int K_BAD = -1, K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4, K_ADDI = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    int total = 0;
    int bad   = 0;

    mips_multicycle_ctrl_if bus_a ();
    mips_multicycle_ctrl_if bus_b ();
    mips_multicycle_ctrl_if bus_c ();

    assign bus_a.opcode = opcode;    assign bus_a.funct = funct;
    assign bus_a.zero   = zero;      assign bus_a.mem_ready = mem_ready;
    assign bus_b.opcode = opcode;    assign bus_b.funct = funct;
    assign bus_b.zero   = zero;      assign bus_b.mem_ready = mem_ready;
    assign bus_c.opcode = opcode;    assign bus_c.funct = funct;
    assign bus_c.zero   = zero;      assign bus_c.mem_ready = mem_ready;

    logic [3:0]  state_a, state_b, state_c;
    logic        done_a, done_b, done_c;
    logic        ill_a, ill_b, ill_c;
    logic [15:0] retired_a, retired_c;
    logic [1:0]  retired_b;

    mips_multicycle_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .bus(bus_a),
        .state(state_a), .instr_done(done_a), .illegal(ill_a), .retired(retired_a)
    );

    mips_multicycle_ctrl #(.ICNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .bus(bus_b),
        .state(state_b), .instr_done(done_b), .illegal(ill_b), .retired(retired_b)
    );

    mips_multicycle_ctrl #(.ENABLE_ADDI(0), .ENABLE_J(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .bus(bus_c),
        .state(state_c), .instr_done(done_c), .illegal(ill_c), .retired(retired_c)
    );

    always #5 clk = ~clk;

    // {pc_en,iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,
    //  alu_src_a,alu_src_b[1:0],pc_source[1:0],alu_ctl[3:0]}
    logic [16:0] ctrl_a, ctrl_b;
    assign ctrl_a = {bus_a.pc_en, bus_a.iord, bus_a.mem_read, bus_a.mem_write, bus_a.ir_write,
                     bus_a.reg_dst, bus_a.mem_to_reg, bus_a.reg_write, bus_a.alu_src_a,
                     bus_a.alu_src_b, bus_a.pc_source, bus_a.alu_ctl};
    assign ctrl_b = {bus_b.pc_en, bus_b.iord, bus_b.mem_read, bus_b.mem_write, bus_b.ir_write,
                     bus_b.reg_dst, bus_b.mem_to_reg, bus_b.reg_write, bus_b.alu_src_a,
                     bus_b.alu_src_b, bus_b.pc_source, bus_b.alu_ctl};

    // ---------------- behavioural model ----------------
    bit          m_idle = 1'b1;
    bit          m_trap = 1'b0;
    int          m_kind = K_BAD;
    int          m_step = 0;
    int unsigned m_retired = 0;
    int          trap_cycles = 0;

    function automatic bit funct_legal(input logic [5:0] fn);
        return (fn == 6'b100000) || (fn == 6'b100010) || (fn == 6'b100100) ||
               (fn == 6'b100101) || (fn == 6'b101010);
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b0010;
        endcase
    endfunction

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn,
                                    input bit ea, input bit ej);
        case (op)
            6'b000000: return funct_legal(fn) ? K_R : K_BAD;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b001000: return ea ? K_ADDI : K_BAD;
            6'b000010: return ej ? K_J : K_BAD;
            default:   return K_BAD;
        endcase
    endfunction

    // Total cycles per instruction with no wait states.
    function automatic int seq_len(input int kind);
        case (kind)
            K_R:     return 4;
            K_LW:    return 5;
            K_SW:    return 4;
            K_BEQ:   return 3;
            K_J:     return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int seq_code(input int kind, input int step);
        if (step == 0) return 1;
        if (step == 1) return 2;
        case (kind)
            K_R:     return (step == 2) ? 7 : 8;
            K_LW:    return (step == 2) ? 3 : ((step == 3) ? 4 : 5);
            K_SW:    return (step == 2) ? 3 : 6;
            K_BEQ:   return 9;
            K_J:     return 10;
            default: return (step == 2) ? 11 : 12;
        endcase
    endfunction

    function automatic logic [16:0] exp_ctrl(input int code, input logic mr,
                                             input logic z, input logic [5:0] fn);
        logic pce, iod, mrd, mwr, irw, rdst, m2r, rw, sa;
        logic [1:0] sb, ps;
        logic [3:0] alu;
        {pce, iod, mrd, mwr, irw, rdst, m2r, rw, sa} = '0;
        sb = 2'b00; ps = 2'b00; alu = 4'b0010;
        case (code)
            1:  begin mrd = 1; sb = 2'b01; irw = mr; pce = mr; end
            2:  sb = 2'b11;
            3:  begin sa = 1; sb = 2'b10; end
            4:  begin mrd = 1; iod = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mwr = 1; iod = 1; end
            7:  begin sa = 1; alu = alu_of(fn); end
            8:  begin rw = 1; rdst = 1; end
            9:  begin sa = 1; alu = 4'b0110; ps = 2'b01; pce = z; end
            10: begin pce = 1; ps = 2'b10; end
            11: begin sa = 1; sb = 2'b10; end
            12: rw = 1;
            default: ;
        endcase
        return {pce, iod, mrd, mwr, irw, rdst, m2r, rw, sa, sb, ps, alu};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_waiting(input int code);
        return ((code == 1) || (code == 4) || (code == 6)) && !mem_ready;
    endfunction

    task automatic compare();
        int code;
        bit last;
        code = 0; last = 0;
        if (m_trap) code = 13;
        else if (!m_idle) begin
            code = seq_code(m_kind, m_step);
            last = (m_step >= 2) && (m_step == seq_len(m_kind) - 1) && !m_waiting(code);
        end
        chk("ctrl_a", {15'b0, ctrl_a}, {15'b0, exp_ctrl(code, mem_ready, zero, funct)});
        chk("ctrl_b", {15'b0, ctrl_b}, {15'b0, exp_ctrl(code, mem_ready, zero, funct)});
        chk("state", {28'b0, state_a}, code);
        chk("state_b", {28'b0, state_b}, code);
        chk("done", {31'b0, done_a}, {31'b0, last});
        chk("illegal", {31'b0, ill_a}, {31'b0, m_trap});
        chk("retired", {16'b0, retired_a}, m_retired % 65536);
        chk("retired_b", {30'b0, retired_b}, m_retired % 4);
    endtask

    task automatic model_step();
        int code;
        if (m_trap) begin
            trap_cycles++;
        end else if (m_idle) begin
            if (en) begin m_idle = 0; m_step = 0; end
        end else if (m_step == 0) begin
            if (mem_ready) m_step = 1;
        end else if (m_step == 1) begin
            m_kind = classify(opcode, funct, 1'b1, 1'b1);
            if (m_kind == K_BAD) begin m_trap = 1; trap_cycles = 0; end
            else m_step = 2;
        end else begin
            code = seq_code(m_kind, m_step);
            if (!m_waiting(code)) begin
                if (m_step == seq_len(m_kind) - 1) begin
                    m_retired++;
                    if (en) m_step = 0; else m_idle = 1;
                end else begin
                    m_step++;
                end
            end
        end
    endtask

    task automatic setin(input logic e, input logic [5:0] op, input logic [5:0] fn,
                         input logic mr, input logic z);
        @(negedge clk);
        en = e; opcode = op; funct = fn; mem_ready = mr; zero = z;
        #1;
        compare();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
    endtask

    // Async reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        chk("rst_state", {28'b0, state_a}, 0);
        chk("rst_ctrl", {15'b0, ctrl_a}, 32'h2);
        chk("rst_retired", {16'b0, retired_a}, 0);
        chk("rst_retired_b", {30'b0, retired_b}, 0);
        chk("rst_illegal", {31'b0, ill_a}, 0);
        chk("rst_done", {31'b0, done_a}, 0);
        chk("rst_c_state", {28'b0, state_c}, 0);
        m_idle = 1; m_trap = 0; m_step = 0; m_retired = 0; m_kind = K_BAD;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int r_st [4];
        int lw_st[7];
        logic lw_mr[7];
        int wexp [4];
        logic [5:0] op, fn, fns[5];
        r_st  = '{1, 2, 7, 8};
        lw_st = '{1, 2, 3, 4, 4, 4, 5};
        lw_mr = '{1, 1, 1, 0, 0, 1, 1};
        wexp  = '{1, 2, 3, 0};
        fns   = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        rst_n = 1'b0; en = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        do_reset();

        // R-type sub
        setin(1, 6'b000000, 6'b100010, 1, 0);
        chk("idle_state", {28'b0, state_a}, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            setin(i != 3, 6'b000000, 6'b100010, 1, 0);
            chk("r_state", {28'b0, state_a}, r_st[i]);
            if (i == 2) chk("r_alu", {28'b0, bus_a.alu_ctl}, 32'h6);
            if (i == 3) begin
                chk("r_wb", {30'b0, bus_a.reg_write, bus_a.reg_dst}, 32'h3);
                chk("r_ret0", {16'b0, retired_a}, 0);
            end
            tick();
        end
        setin(0, 6'b000000, 6'b100010, 1, 0);
        chk("r_ret1", {16'b0, retired_a}, 1);
        tick();

        // lw with two MEMRD wait states
        setin(1, 6'b100011, 6'b000000, 1, 0);
        tick();
        for (int i = 0; i < 7; i++) begin
            setin(i != 6, 6'b100011, 6'b000000, lw_mr[i], 0);
            chk("lw_state", {28'b0, state_a}, lw_st[i]);
            if (lw_st[i] == 4) chk("lw_rd", {30'b0, bus_a.mem_read, bus_a.iord}, 32'h3);
            if (i == 6) begin
                chk("lw_wb", {30'b0, bus_a.reg_write, bus_a.mem_to_reg}, 32'h3);
                chk("lw_done", {31'b0, done_a}, 1);
            end
            tick();
        end

        // beq taken and not taken
        for (int zb = 1; zb >= 0; zb--) begin
            setin(1, 6'b000100, 6'b000000, 1, zb[0]);
            tick();
            for (int i = 0; i < 3; i++) begin
                setin(i != 2, 6'b000100, 6'b000000, 1, zb[0]);
                if (i == 2) begin
                    chk("beq_pcen", {31'b0, bus_a.pc_en}, zb);
                    chk("beq_pcsrc", {30'b0, bus_a.pc_source}, 32'h1);
                    chk("beq_done", {31'b0, done_a}, 1);
                end
                tick();
            end
        end

        // Five back-to-back jumps; ICNT_W=2 copy must wrap. DUT C traps on j.
        do_reset();
        setin(1, 6'b000010, 6'b000000, 1, 0);
        tick();
        for (int i = 0; i < 15; i++) begin
            setin(i != 14, 6'b000010, 6'b000000, 1, 0);
            chk("j_busy", {31'b0, state_a != 4'd0}, 1);
            if (i > 0 && (i % 3) == 0) chk("wrap", {30'b0, retired_b}, wexp[i/3-1]);
            if (i == 2) chk("c_j_trap", {28'b0, state_c}, 13);
            tick();
        end
        setin(0, 6'b000010, 6'b000000, 1, 0);
        chk("wrap_last", {30'b0, retired_b}, 1);
        chk("c_illegal", {31'b0, ill_c}, 1);
        chk("c_retired", {16'b0, retired_c}, 0);
        tick();

        // Illegal opcode, then illegal funct
        for (int t = 0; t < 2; t++) begin
            do_reset();
            op = (t == 0) ? 6'b111111 : 6'b000000;
            fn = (t == 0) ? 6'b000000 : 6'b000001;
            for (int i = 0; i < 13; i++) begin
                setin(1, op, fn, 1, 0);
                if (i >= 3) begin
                    chk("trap_state", {28'b0, state_a}, 13);
                    chk("trap_flag", {31'b0, ill_a}, 1);
                end
                tick();
            end
        end

        // addi: normal on A, trap on C
        do_reset();
        setin(1, 6'b001000, 6'b000000, 1, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            setin(i != 3, 6'b001000, 6'b000000, 1, 0);
            if (i == 2) chk("c_addi_trap", {28'b0, state_c}, 13);
            if (i == 3) chk("addi_wb", {29'b0, bus_a.reg_write, bus_a.reg_dst, bus_a.mem_to_reg}, 32'h4);
            tick();
        end

        // Reset while waiting in MEMRD
        setin(1, 6'b100011, 6'b000000, 1, 0); tick();
        setin(1, 6'b100011, 6'b000000, 1, 0); tick();
        setin(1, 6'b100011, 6'b000000, 1, 0); tick();
        setin(1, 6'b100011, 6'b000000, 1, 0); tick();
        setin(1, 6'b100011, 6'b000000, 0, 0);
        chk("memrd_before_rst", {28'b0, state_a}, 4);
        tick();
        do_reset();

        // Randomised traffic
        op = 6'b000000; fn = 6'b100000;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int r;
            if (m_trap && trap_cycles >= 10) begin
                do_reset();
            end else if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end
            if (m_idle || (!m_trap && m_step == 0)) begin
                r  = $urandom_range(0, 19);
                fn = 6'($urandom_range(0, 63));
                if (r < 4)       begin op = 6'b000000; fn = fns[$urandom_range(0, 4)]; end
                else if (r < 7)  op = 6'b100011;
                else if (r < 10) op = 6'b101011;
                else if (r < 13) op = 6'b000100;
                else if (r < 16) op = 6'b000010;
                else if (r < 18) op = 6'b001000;
                else if (r == 18) begin
                    op = 6'($urandom_range(0, 63));
                    if (op == 6'b000000 || classify(op, 6'b100000, 1'b1, 1'b1) != K_BAD)
                        op = 6'b111111;
                end else begin
                    op = 6'b000000;
                    if (funct_legal(fn)) fn = 6'b000001;
                end
            end
            setin($urandom_range(0, 9) != 0, op, fn,
                  $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mips_multicycle_ctrl
`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle MIPS control unit: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback steps. It drives datapath mux selects, register/memory/PC enables and a 4-bit ALU control code. It extends the single-cycle decoder with:
- `addi` and `j` support
- memory wait-state stalls
- sticky illegal-instruction trap
- retired-instruction counter

It sits between the instruction register and the shared-ALU/shared-memory datapath.

## Interface
**Parameters**
- `ENABLE_ADDI`, default 1: decode opcode 001000; when 0, it is illegal.
- `ENABLE_J`, default 1: decode opcode 000010; when 0, it is illegal.
- `ICNT_W`, default 16: width of the retired-instruction counter.

**Ports**
- `clk` in 1: clock. One clock domain.
- `rst_n` in 1: asynchronous active-low reset.
- `en` in 1: allow start of the next instruction.
- `opcode` in 6: IR[31:26]; stable from DECODE onward.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory access completes this cycle.
- `pc_en` out 1: PC load.
- `iord` out 1: address select (0=PC, 1=ALUOut).
- `mem_read`, `mem_write`, `ir_write` out 1 each.
- `reg_dst` out 1: 1=rd, 0=rt.
- `mem_to_reg` out 1: writeback data (1=MDR).
- `reg_write` out 1.
- `alu_src_a` out 1: 0=PC, 1=A.
- `alu_src_b` out 2: 00=B, 01=4, 10=sign-extended imm, 11=imm<<2.
- `pc_source` out 2: 00=ALU result, 01=ALUOut, 10=jump target.
- `alu_ctl` out 4: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt.
- `state` out 4: current state, for debug.
- `instr_done` out 1: single-cycle pulse on the last cycle of an instruction.
- `illegal` out 1: sticky trap flag.
- `retired` out `ICNT_W`: completed-instruction count.

## Operation
**States** (encoding in parentheses)
- IDLE(0): all outputs 0; → FETCH when `en`=1.
- FETCH(1): `mem_read`, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, add. `ir_write` and `pc_en` assert only when `mem_ready`=1. Hold while `mem_ready`=0; → DECODE.
- DECODE(2): `alu_src_a`=0, `alu_src_b`=11, add. Routes by opcode:
  - 000000 → EXEC
  - 100011 / 101011 → MEMADR
  - 000100 → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP
  - anything else → TRAP
- MEMADR(3): `alu_src_a`=1, `alu_src_b`=10, add; → MEMRD (lw) or MEMWR (sw).
- MEMRD(4): `mem_read`, `iord`=1. Hold until `mem_ready`; → MEMWB.
- MEMWB(5): `reg_write`, `mem_to_reg`=1, `reg_dst`=0.
- MEMWR(6): `mem_write`, `iord`=1. Hold until `mem_ready`. Final state.
- EXEC(7): `alu_src_a`=1, `alu_src_b`=00, `alu_ctl` from `funct`; → ALUWB.
- ALUWB(8): `reg_write`, `reg_dst`=1, `mem_to_reg`=0.
- BRANCH(9): `alu_src_a`=1, `alu_src_b`=00, sub, `pc_source`=01, `pc_en`=`zero`.
- JUMP(10): `pc_en`=1, `pc_source`=10.
- ADDIEX(11): `alu_src_a`=1, `alu_src_b`=10, add; → ADDIWB.
- ADDIWB(12): `reg_write`, `reg_dst`=0, `mem_to_reg`=0.
- TRAP(13): all enables 0, `illegal`=1. Exits only on reset.

**Final states:** MEMWB, MEMWR (when `mem_ready`=1), ALUWB, BRANCH, JUMP, ADDIWB.
- Each pulses `instr_done` and increments `retired`. `retired` wraps modulo 2^`ICNT_W`.
- Next state is FETCH if `en`=1, otherwise IDLE.

**Rules**
- R-type `funct` map: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other `funct` on opcode 000000 → TRAP, checked in DECODE.
- Outputs not listed for a state are 0. `alu_ctl` defaults to 0010 (add).
- Deasserting `en` mid-instruction has no effect; it is sampled only in final states and IDLE.

## Timing
- **Reset:**
  - state=IDLE.
  - All outputs 0, except `alu_ctl`=0010 and `state`=0.
  - `retired`=0, `illegal`=0.
  - Reset mid-instruction aborts immediately; no partial writeback follows.
- **Latency with zero wait states:** R 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4. Each `mem_ready`=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- **Timing style:** all outputs are combinational from the registered state, plus `mem_ready`/`zero` gating. No output depends on `opcode` except through state.
- **Back-to-back:** with `en`=1 the final cycle is followed directly by FETCH; no bubble.
- **Illegal opcode:** TRAP is entered in the cycle after DECODE, with no `instr_done` and no `retired` increment.

## Structure
- Package `mips_ctrl_pkg` holds:
  - state enum
  - opcode and funct constants
  - `alu_ctl` codes
  - `alu_src_b` / `pc_source` encodings
- Sub-module `mips_alu_ctrl` (combinational) maps ALUOp + `funct` to `alu_ctl` and `funct_ok`.

## Test plan
- **Reset:** `rst_n`=0 mid-MEMRD → state=0 and all enables 0 immediately; `retired`=0.
- **R-type:** opcode 000000 / funct 100010, `mem_ready`=1 → states 1,2,7,8. `alu_ctl`=0110 in EXEC; `reg_write`=`reg_dst`=1 in cycle 4; `retired` 0→1.
- **lw with stalls:** 100011 with `mem_ready`=0 for 2 cycles in MEMRD → 7 cycles total. `mem_read`/`iord` held; `reg_write`+`mem_to_reg` in the last cycle.
- **beq:** 000100 with `zero`=1 → `pc_en`=1, `pc_source`=01 in cycle 3. With `zero`=0 → `pc_en`=0. Both pulse `instr_done`.
- **Illegal:** opcode 111111, and separately 000000 with funct 000001 → state 13, `illegal`=1 held for 10 cycles, `retired` unchanged. With `ENABLE_J`=0, opcode 000010 also traps.
- **Counter wrap:** `ICNT_W`=2, 5 back-to-back j instructions with `en`=1 → `retired` sequence 1,2,3,0,1, with no IDLE cycles between instructions.
